uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 94 +++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and its consumer.
// Registered read port, occupancy count and a sticky overflow flag for dropped words.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;

  logic pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (ADDR_WIDTH+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign pop  = rd_en && !empty;
  assign push = data_valid && (!full || pop);
  assign drop = data_valid && full && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = pop;
    overflow_d  = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    // A new drop outranks a simultaneous clear.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; count gating keeps stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= P_DATA;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          data_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_rd_valid = 1'b0;
  logic [DW-1:0] m_rd_data = '0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus, advance the reference model, sample 1 time unit after the edge.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic re, input logic oc);
    bit p, dr, pu;
    data_valid = dv; P_DATA = d; rd_en = re; ovf_clr = oc;
    p  = re && (q.size() != 0);
    dr = dv && (q.size() == DEPTH) && !p;
    pu = dv && !dr;
    m_rd_valid = p;
    if (p)  m_rd_data = q.pop_front();
    if (pu) q.push_back(d);
    if (dr)      m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    @(posedge CLK); #1;
    data_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    data_valid = 1'b1; P_DATA = 8'hEE;
    #2;
    n_cmp++;
    if ({rd_valid, rd_data, count, empty, full, overflow} !== {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got rv=%0b rd=%h cnt=%0d e=%0b f=%0b ovf=%0b, expected rv=0 rd=00 cnt=0 e=1 f=0 ovf=0",
               rd_valid, rd_data, count, empty, full, overflow);
    end
    @(posedge CLK); @(posedge CLK); #1;
    data_valid = 1'b0;
    RST = 1'b1;
    model_reset();
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL write_during_reset: got cnt=%0d e=%0b, expected cnt=0 e=1", count, empty);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL basic_pop1: got rv=%0b rd=%h, expected rv=1 rd=a5", rd_valid, rd_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL basic_pop2: got rv=%0b rd=%h, expected rv=1 rd=3c", rd_valid, rd_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h3C || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_empty_pop: got rv=%0b rd=%h e=%0b, expected rv=0 rd=3c e=1", rd_valid, rd_data, empty);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    n_cmp++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL fill: got f=%0b cnt=%0d ovf=%0b, expected f=1 cnt=8 ovf=0", full, count, overflow);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    n_cmp++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      n_bad++;
      $display("FAIL overflow_set: got ovf=%0b cnt=%0d, expected ovf=1 cnt=8", overflow, count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        n_bad++;
        $display("FAIL drain_%0d: got rv=%0b rd=%h, expected rv=1 rd=%h", i, rd_valid, rd_data, 8'(i));
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL after_drain: got e=%0b ovf=%0b, expected e=1 ovf=1", empty, overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_simul();
    logic [DW-1:0] head;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    head = q[0];
    step(1'b1, 8'h55, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== head || count !== 4'd8 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL full_simul: got rv=%0b rd=%h cnt=%0d ovf=%0b, expected rv=1 rd=%h cnt=8 ovf=0",
               rd_valid, rd_data, count, overflow, head);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_data !== 8'h55 || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL full_simul_tail: got rd=%h e=%0b, expected rd=55 e=1", rd_data, empty);
    end
  endtask

  task automatic test_empty_simul();
    step(1'b1, 8'h99, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== 4'd1) begin
      n_bad++;
      $display("FAIL empty_simul: got rv=%0b cnt=%0d, expected rv=0 cnt=1", rd_valid, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h99) begin
      n_bad++;
      $display("FAIL empty_simul_pop: got rv=%0b rd=%h, expected rv=1 rd=99", rd_valid, rd_data);
    end
  endtask

  task automatic test_ovf_clr();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'hDE, 1'b0, 1'b0);
    step(1'b1, 8'hAD, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_vs_drop: got ovf=%0b, expected ovf=1", overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_alone: got ovf=%0b, expected ovf=0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++;
      if (rd_data !== 8'(8'h40 + i)) begin
        n_bad++;
        $display("FAIL ovf_drain_%0d: got rd=%h, expected rd=%h", i, rd_data, 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_data !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset: got cnt=%0d e=%0b rd=%h, expected cnt=0 e=1 rd=00", count, empty, rd_data);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    model_reset();
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h12) begin
      n_bad++;
      $display("FAIL post_reset_pop: got rv=%0b rd=%h, expected rv=1 rd=12", rd_valid, rd_data);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [DW+7:0] got, exp;
    for (int i = 0; i < cycles; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 10));
      got = {rd_valid, rd_data, count, empty, full, overflow};
      exp = {m_rd_valid, m_rd_data, 4'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random_%0d: got rv=%0b rd=%h cnt=%0d e=%0b f=%0b ovf=%0b, expected rv=%0b rd=%h cnt=%0d e=%0b f=%0b ovf=%0b",
                 i, rd_valid, rd_data, count, empty, full, overflow,
                 m_rd_valid, m_rd_data, q.size(), q.size() == 0, q.size() == DEPTH, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_simul();
    test_empty_simul();
    test_ovf_clr();
    test_reset_mid();
    test_random(20);
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
